// File: rtl/knight_sprite_animator.sv
// Positioned, animated, optionally mirrored sprite renderer with a 3-stage pixel pipeline.
// Define SPRITE_SCALE2X_EN to draw every texel as a 2x2 pixel block.
module knight_sprite_animator #(
    parameter int SPR_W       = 50,
    parameter int SPR_H       = 64,
    parameter int NUM_FRAMES  = 4,
    parameter int IDX_W       = 3,
    parameter int FRAME_TICKS = 6,
    parameter int TRANSP_IDX  = 0,
    parameter int ADDR_W      = $clog2(NUM_FRAMES * SPR_W * SPR_H),
    parameter int FRAME_W     = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic               vga_clk,
    input  logic               Reset,
    input  logic [9:0]         DrawX,
    input  logic [9:0]         DrawY,
    input  logic               blank,
    input  logic [9:0]         pos_x,
    input  logic [9:0]         pos_y,
    input  logic               flip_h,
    input  logic               play,
    input  logic               loop,
    input  logic               restart,
    output logic [ADDR_W-1:0]  rom_address,
    input  logic [IDX_W-1:0]   rom_q,
    output logic [IDX_W-1:0]   pal_index,
    input  logic [3:0]         pal_red,
    input  logic [3:0]         pal_green,
    input  logic [3:0]         pal_blue,
    output logic [3:0]         red,
    output logic [3:0]         green,
    output logic [3:0]         blue,
    output logic               opaque,
    output logic [FRAME_W-1:0] frame_idx,
    output logic               anim_done
);

`ifdef SPRITE_SCALE2X_EN
    localparam int SCALE_SH = 1;
`else
    localparam int SCALE_SH = 0;
`endif

    localparam int BOX_W      = SPR_W << SCALE_SH;
    localparam int BOX_H      = SPR_H << SCALE_SH;
    localparam int FRAME_SIZE = SPR_W * SPR_H;
    localparam int TICK_W     = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;

    localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(NUM_FRAMES - 1);
    localparam logic [TICK_W-1:0]  LAST_TICK  = TICK_W'(FRAME_TICKS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAY,
        ST_DONE
    } state_t;

    // Box test is done one bit wider so a sprite near the right/bottom edge clips instead of wrapping.
    logic [10:0] x_ext, y_ext, px_ext, py_ext;
    logic        in_box;
    logic [9:0]  rel_x, rel_y, tex_x, tex_y, column;
    logic [ADDR_W-1:0] pix_addr;

    assign x_ext  = {1'b0, DrawX};
    assign y_ext  = {1'b0, DrawY};
    assign px_ext = {1'b0, pos_x};
    assign py_ext = {1'b0, pos_y};

    assign in_box = (x_ext >= px_ext) && (x_ext < px_ext + 11'(BOX_W)) &&
                    (y_ext >= py_ext) && (y_ext < py_ext + 11'(BOX_H));

    assign rel_x  = DrawX - pos_x;
    assign rel_y  = DrawY - pos_y;
    assign tex_x  = rel_x >> SCALE_SH;
    assign tex_y  = rel_y >> SCALE_SH;
    assign column = flip_h ? (10'(SPR_W - 1) - tex_x) : tex_x;

    assign pix_addr = ADDR_W'(frame_idx) * ADDR_W'(FRAME_SIZE)
                    + ADDR_W'(tex_y) * ADDR_W'(SPR_W)
                    + ADDR_W'(column);

    logic in_box_s1, blank_s1, in_box_s2, blank_s2;
    logic pix_opaque;

    // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge vga_clk or posedge Reset) begin
        if (Reset) begin
            rom_address <= '0;
            in_box_s1   <= 1'b0;
            blank_s1    <= 1'b0;
            in_box_s2   <= 1'b0;
            blank_s2    <= 1'b0;
        end else begin
            rom_address <= in_box ? pix_addr : '0;
            in_box_s1   <= in_box;
            blank_s1    <= blank;
            in_box_s2   <= in_box_s1;
            blank_s2    <= blank_s1;
        end
    end

    assign pal_index  = rom_q;
    assign pix_opaque = blank_s2 && in_box_s2 && (rom_q != IDX_W'(TRANSP_IDX));

    always_ff @(posedge vga_clk or posedge Reset) begin
        if (Reset) begin
            red    <= '0;
            green  <= '0;
            blue   <= '0;
            opaque <= 1'b0;
        end else begin
            red    <= pix_opaque ? pal_red   : 4'd0;
            green  <= pix_opaque ? pal_green : 4'd0;
            blue   <= pix_opaque ? pal_blue  : 4'd0;
            opaque <= pix_opaque;
        end
    end

    // One tick on the first cycle the beam sits at the origin, so a held origin cannot re-fire.
    logic origin_q, at_origin, frame_tick;

    assign at_origin  = (DrawX == 10'd0) && (DrawY == 10'd0);
    assign frame_tick = at_origin && !origin_q;

    state_t             state_q, state_d;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic [FRAME_W-1:0] frame_d;
    logic               done_d;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        frame_d = frame_idx;
        tick_d  = tick_q;
        done_d  = 1'b0;
        if (restart) begin
            state_d = ST_PLAY;
            frame_d = '0;
            tick_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: frame_d = '0;
                ST_PLAY: begin
                    if (frame_tick && play) begin
                        if (tick_q == LAST_TICK) begin
                            tick_d = '0;
                            if (frame_idx == LAST_FRAME) begin
                                if (loop) begin
                                    frame_d = '0;
                                end else begin
                                    state_d = ST_DONE;
                                    done_d  = 1'b1;
                                end
                            end else begin
                                frame_d = frame_idx + FRAME_W'(1);
                            end
                        end else begin
                            tick_d = tick_q + TICK_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge vga_clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            tick_q    <= '0;
            frame_idx <= '0;
            anim_done <= 1'b0;
            origin_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            frame_idx <= frame_d;
            anim_done <= done_d;
            origin_q  <= at_origin;
        end
    end

endmodule

// File: tb/tb_knight_sprite_animator.sv
// Directed bench for knight_sprite_animator: reset, pixel pipeline, clipping, transparency, animation FSM.
module tb_knight_sprite_animator;

    logic        vga_clk = 1'b0;
    logic        Reset;
    logic [9:0]  DrawX, DrawY, pos_x, pos_y;
    logic        blank, flip_h, play, loop, restart;
    logic [13:0] rom_address;
    logic [2:0]  rom_q, pal_index;
    logic [3:0]  pal_red, pal_green, pal_blue, red, green, blue;
    logic        opaque, anim_done;
    logic [1:0]  frame_idx;

    int n_checks = 0;
    int n_fail   = 0;

    logic [13:0] cap_addr;
    logic [3:0]  cap_r, cap_g, cap_b;
    logic        cap_op, cap_op2;
    logic [1:0]  tk_f;
    logic        tk_d;

    always #5 vga_clk = ~vga_clk;

    // Bench palette: distinct, easily hand-computed colours per index.
    assign pal_red   = {1'b1, pal_index};
    assign pal_green = {pal_index, 1'b0};
    assign pal_blue  = {1'b0, ~pal_index};

    knight_sprite_animator dut (
        .vga_clk     (vga_clk),
        .Reset       (Reset),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .blank       (blank),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .flip_h      (flip_h),
        .play        (play),
        .loop        (loop),
        .restart     (restart),
        .rom_address (rom_address),
        .rom_q       (rom_q),
        .pal_index   (pal_index),
        .pal_red     (pal_red),
        .pal_green   (pal_green),
        .pal_blue    (pal_blue),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .opaque      (opaque),
        .frame_idx   (frame_idx),
        .anim_done   (anim_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Holds one pixel for three edges; captures address after S1, opaque after S2 and S3.
    task automatic run_pixel(input logic [9:0] x, input logic [9:0] y, input logic f,
                             input logic b, input logic [2:0] q);
        @(negedge vga_clk);
        DrawX = x; DrawY = y; flip_h = f; blank = b; rom_q = q;
        @(posedge vga_clk); #1 cap_addr = rom_address;
        @(posedge vga_clk); #1 cap_op2 = opaque;
        @(posedge vga_clk); #1;
        cap_r = red; cap_g = green; cap_b = blue; cap_op = opaque;
    endtask

    task automatic do_tick(output logic [1:0] f, output logic d);
        @(negedge vga_clk);
        DrawX = 10'd0; DrawY = 10'd0;
        @(posedge vga_clk); #1;
        f = frame_idx;
        d = anim_done;
        @(negedge vga_clk);
        DrawX = 10'd5; DrawY = 10'd5;
        @(posedge vga_clk); #1;
    endtask

    task automatic do_restart();
        @(negedge vga_clk);
        restart = 1'b1;
        @(posedge vga_clk); #1;
        @(negedge vga_clk);
        restart = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; DrawX = 10'd100; DrawY = 10'd201; blank = 1'b1;
        pos_x = 10'd100; pos_y = 10'd200; flip_h = 1'b0;
        play = 1'b1; loop = 1'b0; restart = 1'b1; rom_q = 3'd5;

        repeat (4) @(posedge vga_clk);
        #1;
        check("rst_red", red, 0);
        check("rst_green", green, 0);
        check("rst_blue", blue, 0);
        check("rst_opaque", opaque, 0);
        check("rst_frame", frame_idx, 0);
        check("rst_addr", rom_address, 0);
        check("rst_done", anim_done, 0);

        @(negedge vga_clk);
        restart = 1'b0; DrawX = 10'd5; DrawY = 10'd5; play = 1'b0;
        Reset = 1'b0;

        run_pixel(10'd150, 10'd201, 1'b0, 1'b1, 3'd5);
        check("right_clip_addr", cap_addr, 0);
        check("right_clip_opaque", cap_op, 0);
        check("right_clip_red", cap_r, 0);

        run_pixel(10'd100, 10'd201, 1'b0, 1'b1, 3'd5);
        check("base_addr", cap_addr, 50);
        check("base_latency_s2", cap_op2, 0);
        check("base_opaque", cap_op, 1);
        check("base_red", cap_r, 13);
        check("base_green", cap_g, 10);
        check("base_blue", cap_b, 2);

        run_pixel(10'd100, 10'd201, 1'b1, 1'b1, 3'd5);
        check("flip_addr", cap_addr, 99);
        check("flip_opaque", cap_op, 1);

        run_pixel(10'd149, 10'd201, 1'b0, 1'b1, 3'd5);
        check("right_edge_addr", cap_addr, 99);
        check("right_edge_opaque", cap_op, 1);

        run_pixel(10'd149, 10'd263, 1'b1, 1'b1, 3'd5);
        check("corner_flip_addr", cap_addr, 3150);
        check("corner_flip_opaque", cap_op, 1);

        run_pixel(10'd100, 10'd264, 1'b0, 1'b1, 3'd5);
        check("bottom_clip_addr", cap_addr, 0);
        check("bottom_clip_opaque", cap_op, 0);

        run_pixel(10'd99, 10'd201, 1'b0, 1'b1, 3'd5);
        check("left_clip_opaque", cap_op, 0);

        run_pixel(10'd120, 10'd210, 1'b0, 1'b1, 3'd0);
        check("transp_addr", cap_addr, 520);
        check("transp_opaque", cap_op, 0);
        check("transp_red", cap_r, 0);
        check("transp_blue", cap_b, 0);

        run_pixel(10'd120, 10'd210, 1'b0, 1'b0, 3'd5);
        check("blanked_opaque", cap_op, 0);
        check("blanked_green", cap_g, 0);

        run_pixel(10'd120, 10'd210, 1'b0, 1'b1, 3'd3);
        check("idx3_red", cap_r, 11);
        check("idx3_green", cap_g, 6);
        check("idx3_blue", cap_b, 4);

        @(negedge vga_clk);
        DrawX = 10'd5; DrawY = 10'd5; play = 1'b1; loop = 1'b0;
        do_tick(tk_f, tk_d);
        check("idle_tick_frame", tk_f, 0);
        check("idle_tick_done", tk_d, 0);

        do_restart();
        check("restart_frame", frame_idx, 0);
        for (int k = 1; k <= 24; k++) begin
            do_tick(tk_f, tk_d);
            check($sformatf("once_frame_k%0d", k), tk_f, (k >= 24) ? 3 : k / 6);
            check($sformatf("once_done_k%0d", k), tk_d, (k == 24) ? 1 : 0);
        end
        check("done_pulse_ends", anim_done, 0);
        for (int k = 0; k < 2; k++) begin
            do_tick(tk_f, tk_d);
            check($sformatf("done_hold_frame_%0d", k), tk_f, 3);
            check($sformatf("done_hold_pulse_%0d", k), tk_d, 0);
        end

        loop = 1'b1;
        do_restart();
        check("restart_from_done_frame", frame_idx, 0);
        for (int k = 1; k <= 24; k++) begin
            do_tick(tk_f, tk_d);
            check($sformatf("loop_frame_k%0d", k), tk_f, (k / 6) % 4);
            check($sformatf("loop_done_k%0d", k), tk_d, 0);
        end

        for (int k = 0; k < 11; k++) do_tick(tk_f, tk_d);
        check("pre_collision_frame", tk_f, 1);

        @(negedge vga_clk);
        restart = 1'b1; DrawX = 10'd0; DrawY = 10'd0;
        @(posedge vga_clk); #1;
        check("collision_frame", frame_idx, 0);
        @(negedge vga_clk);
        restart = 1'b0; DrawX = 10'd5; DrawY = 10'd5;
        for (int k = 1; k <= 6; k++) begin
            do_tick(tk_f, tk_d);
            check($sformatf("post_collision_k%0d", k), tk_f, (k == 6) ? 1 : 0);
        end

        play = 1'b0;
        for (int k = 0; k < 10; k++) begin
            do_tick(tk_f, tk_d);
            check($sformatf("paused_k%0d", k), tk_f, 1);
        end

        run_pixel(10'd100, 10'd201, 1'b0, 1'b1, 3'd5);
        check("frame1_addr", cap_addr, 3250);

        @(negedge vga_clk);
        DrawX = 10'd5; DrawY = 10'd5; play = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            do_tick(tk_f, tk_d);
            check($sformatf("resume_k%0d", k), tk_f, (k == 6) ? 2 : 1);
        end

        @(negedge vga_clk);
        #2 Reset = 1'b1;
        #1;
        check("async_rst_frame", frame_idx, 0);
        check("async_rst_addr", rom_address, 0);
        check("async_rst_opaque", opaque, 0);
        @(negedge vga_clk);
        Reset = 1'b0;
        repeat (2) @(posedge vga_clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
